// File: rtl/fetch_pkg.sv
// fetch_pkg: types and defaults shared by the instruction fetch unit.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = '0;
    typedef enum logic [1:0] {BOOT, RUN, HOLD} fetch_state_e;
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } if_entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: redirect, instruction-memory and decode handshakes of the fetch unit.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int AW = XLEN
) ();
    logic          flush;
    logic [AW-1:0] flush_target;
    logic          jalr;
    logic [AW-1:0] jalr_target;
    logic          PCSrc;
    logic [AW-1:0] br_target;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_rvalid;
    logic [AW-1:0] imem_rdata;
    logic          if_valid;
    logic          if_ready;
    logic [AW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic          misalign;
    modport master (
        input  flush, flush_target, jalr, jalr_target, PCSrc, br_target,
        input  imem_rvalid, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, if_instr, if_pc, misalign
    );
    modport slave (
        output flush, flush_target, jalr, jalr_target, PCSrc, br_target,
        output imem_rvalid, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, misalign
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two synchronous FIFO with occupancy count and single-cycle clear.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rptr, wptr;
    logic             empty, full, do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (clr) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop) rptr <= rptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= din;
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop && !clr));
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, arbitrates redirects against PC+4 and buffers
// in-order fetch responses so decode can stall without losing words.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = XLEN,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = RESET_VECTOR_DEFAULT,
    parameter int                       BUF_DEPTH     = 2
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master bus
);
    localparam int AW = ADDRESS_WIDTH;
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    fetch_state_e  state, state_nx;
    logic [AW-1:0] pc, target;
    logic [AW:0]   f_dout;
    logic [CW-1:0] q_count, f_count;
    logic [CW:0]   occ, occ_nx;
    logic          epoch, redir, issue, pop, push, valid, misalign_q;
    if_entry_t     q_din, q_dout;
    assign redir  = state != BOOT && (bus.flush || bus.jalr || bus.PCSrc);
    assign target = bus.flush ? bus.flush_target :
                    bus.jalr  ? (bus.jalr_target & ~AW'(1)) : bus.br_target;
    assign valid  = q_count != '0;
    assign pop    = valid && bus.if_ready;
    // responses tagged with an older epoch belong to a squashed path
    assign push   = bus.imem_rvalid && f_dout[AW] == epoch;
    assign q_din  = {bus.imem_rdata, f_dout[AW-1:0]};
    // a slot freed by this cycle's pop can be refilled immediately
    assign occ    = (CW+1)'(q_count) + (CW+1)'(f_count) - (CW+1)'(pop);
    assign occ_nx = (redir ? (CW+1)'(0) : (CW+1)'(q_count) + (CW+1)'(push) - (CW+1)'(pop)) +
                    (CW+1)'(f_count) + (CW+1)'(issue) - (CW+1)'(bus.imem_rvalid);
    assign issue  = state != BOOT && !redir && occ < (CW+1)'(BUF_DEPTH);
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= BOOT;
        else state <= state_nx;
    always_comb
        state_nx = (state == BOOT || redir) ? RUN : (occ_nx == (CW+1)'(BUF_DEPTH) ? HOLD : RUN);
    always_comb begin
        bus.imem_req  = issue;
        bus.imem_addr = pc;
        bus.if_valid  = valid;
        bus.if_instr  = valid ? q_dout.instr : '0;
        bus.if_pc     = valid ? q_dout.pc : '0;
        bus.misalign  = misalign_q;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            pc         <= RESET_VECTOR;
            epoch      <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc         <= redir ? (target & ~AW'(3)) : issue ? pc + AW'(4) : pc;
            epoch      <= epoch ^ redir;
            misalign_q <= redir && target[1];
        end
    fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH($bits(if_entry_t))) u_queue (
        .clk(clk), .rst(rst), .clr(redir), .push(push), .din(q_din),
        .pop(pop), .dout(q_dout), .count(q_count)
    );
    fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(AW + 1)) u_inflight (
        .clk(clk), .rst(rst), .clr(1'b0), .push(issue), .din({epoch, pc}),
        .pop(bus.imem_rvalid), .dout(f_dout), .count(f_count)
    );
endmodule
